// File: rtl/fp_add.sv
// Single-cycle IEEE-754 binary32 adder with a registered result.
// Round-to-nearest-even; subnormals read as zero and tiny results flush to zero.
module fp_add (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        sa, sb;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign sa     = a[31];
    assign sb     = b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    logic               sl;
    logic [7:0]         el, es, d;
    logic [23:0]        ml, ms;
    logic [49:0]        wide;
    logic [25:0]        sm_al;
    logic               st;
    logic [27:0]        sum;
    logic [4:0]         pos, lz;
    logic [26:0]        r;
    logic signed [9:0]  exp_n, exp_r;
    logic               rnd_up;
    logic [24:0]        mant;
    logic [22:0]        frac;
    logic [31:0]        s_next;

    // Swap, align, add/subtract, normalize, round and repack in one cycle.
    always_comb begin
        sl     = sa;
        el     = ea;
        ml     = {1'b1, fa};
        es     = eb;
        ms     = {1'b1, fb};
        d      = 8'd0;
        wide   = 50'd0;
        sm_al  = 26'd0;
        st     = 1'b0;
        sum    = 28'd0;
        pos    = 5'd0;
        lz     = 5'd0;
        r      = 27'd0;
        exp_n  = 10'sd0;
        exp_r  = 10'sd0;
        rnd_up = 1'b0;
        mant   = 25'd0;
        frac   = 23'd0;
        s_next = 32'h0000_0000;

        // larger magnitude first; only meaningful when both operands are normal
        if ({eb, fb} > {ea, fa}) begin
            sl = sb;
            el = eb;
            ml = {1'b1, fb};
            es = ea;
            ms = {1'b1, fa};
        end

        // align the smaller significand, folding shifted-out bits into sticky
        d    = el - es;
        wide = {ms, 26'd0} >> d;
        if (d >= 8'd26) begin
            sm_al = 26'd0;
            st    = 1'b1;
        end else begin
            sm_al = wide[49:24];
            st    = |wide[23:0];
        end

        if (sa ^ sb)
            sum = {1'b0, ml, 3'b000} - {1'b0, sm_al, st};
        else
            sum = {1'b0, ml, 3'b000} + {1'b0, sm_al, st};

        // normalize: right by one on carry-out, else left by the leading-zero count
        exp_n = $signed({2'b00, el});
        if (sum[27]) begin
            r     = {sum[27:2], sum[1] | sum[0]};
            exp_n = exp_n + 10'sd1;
        end else begin
            for (int i = 0; i < 27; i++) begin
                if (sum[i])
                    pos = 5'(i);
            end
            lz    = 5'd26 - pos;
            r     = sum[26:0] << lz;
            exp_n = exp_n - $signed({5'd0, lz});
        end

        // round to nearest, ties to even; a carry out bumps the exponent
        rnd_up = r[2] & (r[1] | r[0] | r[3]);
        mant   = {1'b0, r[26:3]} + {24'd0, rnd_up};
        if (mant[24]) begin
            exp_r = exp_n + 10'sd1;
            frac  = mant[23:1];
        end else begin
            exp_r = exp_n;
            frac  = mant[22:0];
        end

        // special operands take priority over the arithmetic path
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb)))
            s_next = QNAN;
        else if (a_inf)
            s_next = a;
        else if (b_inf)
            s_next = b;
        else if (a_zero && b_zero)
            s_next = {sa & sb, 31'd0};
        else if (a_zero)
            s_next = b;
        else if (b_zero)
            s_next = a;
        else if (sum == 28'd0)
            s_next = 32'h0000_0000;
        else if (exp_r >= 10'sd255)
            s_next = {sl, 8'hFF, 23'd0};
        else if (exp_r < 10'sd1)
            s_next = {sl, 31'd0};
        else
            s_next = {sl, exp_r[7:0], frac};
    end

    // Result register, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            s <= 32'h0000_0000;
        else
            s <= s_next;
    end

endmodule

// File: tb/tb_fp_add.sv
// Randomized bench for fp_add against an exact-integer binary32 addition model.
module tb_fp_add;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic [31:0] s;

    logic [31:0] cur_lit   = 32'd0;
    logic        cur_lit_v = 1'b0;

    logic [31:0] exp_s     = 32'd0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_lit   = 32'd0;
    logic        exp_lit_v = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    fp_add dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .s     (s)
    );

    always #5 clk = ~clk;

    // Exact reference: operands become integers in units of 2^-149, are summed
    // exactly, then rounded once to binary32 with ties to even.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic [299:0] nx, ny, mag, rem, half, one, keep;
        logic         sgn;
        int           p, e, sh;
        logic         x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        x_zero = (x[30:23] == 8'h00);
        y_zero = (y[30:23] == 8'h00);
        if (x_nan || y_nan || (x_inf && y_inf && x[31] != y[31])) return 32'h7FC0_0000;
        if (x_inf) return {x[31], 8'hFF, 23'd0};
        if (y_inf) return {y[31], 8'hFF, 23'd0};
        if (x_zero && y_zero) return {x[31] & y[31], 31'd0};
        if (x_zero) return y;
        if (y_zero) return x;
        one = 300'd1;
        nx  = 300'({1'b1, x[22:0]}) << (int'(x[30:23]) - 1);
        ny  = 300'({1'b1, y[22:0]}) << (int'(y[30:23]) - 1);
        if (x[31] == y[31]) begin
            mag = nx + ny; sgn = x[31];
        end else if (nx > ny) begin
            mag = nx - ny; sgn = x[31];
        end else if (ny > nx) begin
            mag = ny - nx; sgn = y[31];
        end else begin
            return 32'h0000_0000;
        end
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {sgn, 31'd0};
        e    = p - 22;
        sh   = p - 23;
        keep = mag >> sh;
        rem  = mag & ((one << sh) - one);
        half = (sh > 0) ? (one << (sh - 1)) : 300'd0;
        if (sh > 0 && (rem > half || (rem == half && keep[0]))) keep = keep + one;
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        if (e < 1) return {sgn, 31'd0};
        return {sgn, 8'(e), keep[22:0]};
    endfunction

    // Random operand biased toward specials, zeros, subnormals and extreme exponents.
    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            5: v[30:23] = 8'hFF;
            6: begin v[30:23] = 8'h00; if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0; end
            7: v[30:23] = 8'hFE - 8'($urandom_range(0, 2));
            8: v[30:23] = 8'($urandom_range(1, 3));
            9: if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
            default: ;
        endcase
        if (k == 5 && $urandom_range(0, 2) != 0) v[22:0] = 23'd0;
        return v;
    endfunction

    // Expected-value pipeline: one cycle, cleared by reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_valid <= 1'b0;
            exp_lit_v <= 1'b0;
        end else begin
            exp_s     <= ref_add(a, b);
            exp_lit   <= cur_lit;
            exp_lit_v <= cur_lit_v;
            exp_valid <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: a=%h b=%h got %h expected %h at %0t", name, a, b, act, req, $time);
        end
    endtask

    // Compare process: reset value shortly after reset rises and while held,
    // otherwise the DUT against the model (and literals where given).
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            #1;
            chk("reset", s, 32'h0000_0000);
        end else if (exp_valid) begin
            chk("sum", s, exp_s);
            if (exp_lit_v) begin
                chk("literal", s, exp_lit);
                chk("model_literal", exp_s, exp_lit);
            end
        end
    end

    task automatic drive(input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] lit, input logic lv);
        @(posedge clk);
        #2;
        a         = va;
        b         = vb;
        cur_lit   = lit;
        cur_lit_v = lv;
    endtask

    logic [31:0] dir_a [0:17] = '{32'h3F750000, 32'h3F800000, 32'h3F800000, 32'h4B800000,
                                  32'h4B800001, 32'h7F7FFFFF, 32'h7F800000, 32'h7FC00001,
                                  32'h3FC00000, 32'h3F800001, 32'h00000001, 32'h80000000,
                                  32'h00000000, 32'h7F800000, 32'hFF800000, 32'h00800001,
                                  32'h4B7FFFFF, 32'h40490FDB};
    logic [31:0] dir_b [0:17] = '{32'h3FC00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                                  32'h3F800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000,
                                  32'hBF800000, 32'hBF800000, 32'h3F800000, 32'h80000000,
                                  32'h80000000, 32'h3F800000, 32'hFF800000, 32'h80800000,
                                  32'h3F000000, 32'h00000000};
    logic [31:0] dir_s [0:17] = '{32'h401D4000, 32'h40000000, 32'h00000000, 32'h4B800000,
                                  32'h4B800002, 32'h7F800000, 32'h7FC00000, 32'h7FC00000,
                                  32'h3F000000, 32'h34000000, 32'h3F800000, 32'h80000000,
                                  32'h00000000, 32'h7F800000, 32'hFF800000, 32'h00000000,
                                  32'h4B800000, 32'h40490FDB};

    task automatic random_burst(input int n);
        logic [31:0] va, vb;
        for (int i = 0; i < n; i++) begin
            va = rand_fp();
            case ($urandom_range(0, 3))
                0: vb = {~va[31], va[30:4], 4'($urandom)};
                1: vb = {~va[31], va[30:23] - 8'($urandom_range(0, 1)), 23'($urandom)};
                default: vb = rand_fp();
            endcase
            drive(va, vb, 32'd0, 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        for (int i = 0; i < 18; i++) drive(dir_a[i], dir_b[i], dir_s[i], 1'b1);
        random_burst(2000);
        // mid-stream reset with a nonzero result in the register
        drive(32'h3F800000, 32'h3F800000, 32'h40000000, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;
        a = 32'h3F750000;
        b = 32'h3FC00000;
        cur_lit   = 32'h401D4000;
        cur_lit_v = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        drive(32'h3FC00000, 32'hBF800000, 32'h3F000000, 1'b1);
        random_burst(500);
        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
